// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler vector
// and the packed views of the SR and Cause registers.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    // A delay-slot victim restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
        logic [31:0] v;
        v = bd ? pc - 32'd4 : pc;
        return {v[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] sr_word(input sr_t sr);
        return {16'd0, sr.im, 8'd0, sr.exl, sr.ie};
    endfunction

    function automatic logic [31:0] cause_word(input cause_t c);
        return {c.bd, 15'd0, c.ip, 3'd0, c.exc_code, 2'd0};
    endfunction

endpackage

// File: rtl/cp0_irq_gen.sv
// Combinational interrupt/exception request logic; a pending interrupt
// outranks a simultaneous exception when choosing the recorded ExcCode.
module cp0_irq_gen
    import cp0_pkg::*;
(
    input  logic       reset,
    input  logic [5:0] hw_int,
    input  logic [4:0] exc_code,
    input  sr_t        sr,
    output logic       irq,
    output logic [4:0] sel_exc_code
);

    logic int_req;
    logic exc_req;

    assign int_req      = (|(hw_int & sr.im)) & sr.ie & ~sr.exl;
    assign exc_req      = (exc_code != EXC_INT) & ~sr.exl;
    assign irq          = reset & (int_req | exc_req);
    assign sel_exc_code = int_req ? EXC_INT : exc_code;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR/Cause/EPC/PRId) with exception entry,
// eret EXL clear and the mfc0/mtc0 access ports.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_3A7C,
    parameter logic [5:0]  IM_RESET   = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        we,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IRQ,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    sr_t         sr_q;
    cause_t      cause_q;
    logic [31:0] epc_q;
    logic [4:0]  sel_exc_code;

    cp0_irq_gen u_irq_gen (
        .reset        (reset),
        .hw_int       (HWInt),
        .exc_code     (ExcCode),
        .sr           (sr_q),
        .irq          (IRQ),
        .sel_exc_code (sel_exc_code)
    );

    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values; later assignments override earlier
    // ones, which is how EXLClr beats the EXL bit of a same-cycle SR write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q    <= '{im: IM_RESET, exl: 1'b0, ie: 1'b0};
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            cause_q.ip <= HWInt;
            if (IRQ) begin
                sr_q.exl         <= 1'b1;
                cause_q.bd       <= BD;
                cause_q.exc_code <= sel_exc_code;
                epc_q            <= epc_target(PC, BD);
            end else begin
                if (we && A2 == REG_SR) begin
                    sr_q.im  <= DIn[15:10];
                    sr_q.exl <= DIn[1];
                    sr_q.ie  <= DIn[0];
                end
                if (we && A2 == REG_EPC) begin
                    epc_q <= {DIn[31:2], 2'b00};
                end
                if (EXLClr) begin
                    sr_q.exl <= 1'b0;
                end
            end
        end
    end

    assign EPC = epc_q;

    // NOTE: the default assignment before the case keeps this block purely
    // combinational; a missing path would otherwise infer a latch.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_word(sr_q);
            REG_CAUSE: DOut = cause_word(cause_q);
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: expected values are queued when stimulus is
// applied and popped against the DUT outputs at each comparison point.
module tb_cp0_unit;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        we;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IRQ;
    logic [31:0] EPC;
    logic [31:0] DOut;

    cp0_unit #(
        .PRID_VALUE (32'h0000_3A7C),
        .IM_RESET   (6'b000000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .A1      (A1),
        .A2      (A2),
        .DIn     (DIn),
        .we      (we),
        .PC      (PC),
        .BD      (BD),
        .ExcCode (ExcCode),
        .HWInt   (HWInt),
        .EXLClr  (EXLClr),
        .IRQ     (IRQ),
        .EPC     (EPC),
        .DOut    (DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h required an expected entry", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value)
            else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq(input string tag, input logic exp_irq);
        push(tag, {31'd0, exp_irq});
        #1;
        check({31'd0, IRQ});
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] value);
        A1 = a;
        push(tag, value);
        #1;
        check(DOut);
    endtask

    initial begin
        reset = 1'b0; A1 = '0; A2 = '0; DIn = '0; we = 1'b0; PC = '0; BD = 1'b0;
        ExcCode = EXC_RI; HWInt = 6'h3F; EXLClr = 1'b0;

        // Reset held two edges with every request line active.
        chk_irq("irq_in_reset_0", 1'b0);
        tick();
        chk_irq("irq_in_reset_1", 1'b0);
        tick();
        chk_irq("irq_in_reset_2", 1'b0);
        reset = 1'b1; HWInt = 6'h00; ExcCode = EXC_INT;
        rd(REG_SR,    "sr_after_reset",    32'h0000_0000);
        rd(REG_CAUSE, "cause_after_reset", 32'h0000_0000);
        push("epc_after_reset", 32'h0000_0000); #1; check(EPC);
        chk_irq("irq_idle", 1'b0);

        // Interrupt entry.
        we = 1'b1; A2 = REG_SR; DIn = 32'h0000_0401;
        tick();
        we = 1'b0;
        rd(REG_SR, "sr_written", 32'h0000_0401);
        HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
        chk_irq("irq_int_entry", 1'b1);
        tick();
        push("epc_int_entry", 32'h0000_3010); #1; check(EPC);
        rd(REG_CAUSE, "cause_int_entry", 32'h0000_0400);
        rd(REG_SR,    "sr_exl_set",      32'h0000_0403);
        chk_irq("irq_blocked_by_exl", 1'b0);

        // mtc0 SR together with EXLClr: EXL ends up 0, IM/IE from DIn.
        HWInt = 6'h00;
        we = 1'b1; A2 = REG_SR; DIn = 32'h0000_0402; EXLClr = 1'b1;
        tick();
        we = 1'b0; EXLClr = 1'b0;
        rd(REG_SR, "sr_mtc0_with_eret", 32'h0000_0400);

        // Delay-slot exception with interrupts disabled.
        ExcCode = EXC_ADEL; PC = 32'h0000_3024; BD = 1'b1;
        chk_irq("irq_exc_entry", 1'b1);
        tick();
        ExcCode = EXC_INT; BD = 1'b0;
        push("epc_delay_slot", 32'h0000_3020); #1; check(EPC);
        rd(REG_CAUSE, "cause_delay_slot", 32'h8000_0010);

        // Nested events while EXL=1 stay blocked; IP still tracks HWInt.
        HWInt = 6'h3F; ExcCode = EXC_OV;
        chk_irq("irq_nested_blocked", 1'b0);
        tick();
        rd(REG_CAUSE, "cause_pending_ip", 32'h8000_FC10);
        HWInt = 6'h00; ExcCode = EXC_INT;

        // eret alone, then enable interrupts.
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd(REG_SR, "sr_after_eret", 32'h0000_0400);
        we = 1'b1; A2 = REG_SR; DIn = 32'h0000_0401;
        tick();

        // Interrupt beats a simultaneous exception; same-cycle mtc0 EPC dropped.
        A2 = REG_EPC; DIn = 32'hDEAD_BEEF;
        HWInt = 6'b000001; ExcCode = EXC_OV; PC = 32'h0000_4000; BD = 1'b0;
        chk_irq("irq_priority", 1'b1);
        tick();
        we = 1'b0; ExcCode = EXC_INT;
        rd(REG_CAUSE, "cause_priority", 32'h0000_0400);
        push("epc_mtc0_dropped", 32'h0000_4000); #1; check(EPC);

        // mtc0 EPC while no request is taken; low bits forced to zero.
        we = 1'b1; A2 = REG_EPC; DIn = 32'hDEAD_BEEF;
        tick();
        we = 1'b0;
        push("epc_mtc0", 32'hDEAD_BEEC); #1; check(EPC);

        // eret with an enabled interrupt still pending raises IRQ next cycle.
        chk_irq("irq_before_eret", 1'b0);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        chk_irq("irq_after_eret", 1'b1);
        // Delay-slot entry at a PC that wraps below zero.
        PC = 32'h0000_0002; BD = 1'b1;
        tick();
        BD = 1'b0;
        push("epc_wrap", 32'hFFFF_FFFC); #1; check(EPC);
        rd(REG_CAUSE, "cause_wrap", 32'h8000_0400);

        // Reads and software-ignored writes.
        HWInt = 6'h2A;
        we = 1'b1; A2 = REG_CAUSE; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = REG_PRID;
        tick();
        we = 1'b0;
        rd(REG_PRID,  "prid",         32'h0000_3A7C);
        rd(REG_CAUSE, "cause_ip_read", 32'h8000_A800);
        rd(5'd7,      "unmapped_read", 32'h0000_0000);

        // Reset mid-exception forces IRQ low and clears state.
        EXLClr = 1'b1; ExcCode = EXC_ADES;
        tick();
        EXLClr = 1'b0;
        chk_irq("irq_exc_pending", 1'b1);
        reset = 1'b0;
        chk_irq("irq_forced_low", 1'b0);
        tick();
        rd(REG_SR, "sr_mid_reset", 32'h0000_0000);
        push("epc_mid_reset", 32'h0000_0000); #1; check(EPC);

        if (sb_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
